// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters, each tenure capped at MAX_HOLD writes.
// Define SHARED_REG_PRIO0_EN to give requester 0 fixed top priority at every arbitration point.
module shared_reg_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     din,
   output logic [NREQ-1:0]           gnt,
   output logic [$clog2(NREQ)-1:0]   gnt_id,
   output logic [WIDTH-1:0]          q,
   output logic                      q_valid,
   output logic                      busy
);

   localparam int IDW = $clog2(NREQ);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t            state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [IDW-1:0]    gnt_id_q;
   logic [IDW-1:0]    last_q;
   logic [WIDTH-1:0]  q_q;
   logic              q_valid_q;
   logic [3:0]        hold_q;

   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    cand_id [NREQ];
   logic [NREQ-1:0]   cand_req;
   logic [IDW-1:0]    rr_id_d;
   logic [IDW-1:0]    arb_id_d;
   logic [NREQ-1:0]   arb_onehot_d;
   logic              req_any;
   logic              cur_req;
   logic              do_write;

   // While granted, the search starts after the current grantee, which becomes "last" on release.
   assign ptr      = (state_q == S_GRANT) ? gnt_id_q : last_q;
   assign req_any  = |req;
   assign cur_req  = |(req & gnt_q);
   assign do_write = cur_req && (hold_q < 4'(MAX_HOLD));

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         logic [IDW:0] sum;
         assign sum          = {1'b0, ptr} + (IDW+1)'(gi + 1);
         assign cand_id[gi]  = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];
         assign cand_req[gi] = req[cand_id[gi]];
      end
   endgenerate

   // Scan from the highest offset down so the nearest requester after ptr wins.
   always_comb begin
      rr_id_d = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            rr_id_d = cand_id[k];
         end
      end
   end

`ifdef SHARED_REG_PRIO0_EN
   assign arb_id_d = req[0] ? '0 : rr_id_d;
`else
   assign arb_id_d = rr_id_d;
`endif

   always_comb begin
      arb_onehot_d           = '0;
      arb_onehot_d[arb_id_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_q    <= IDW'(NREQ - 1);
         q_q       <= '0;
         q_valid_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         q_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  state_q  <= S_GRANT;
                  gnt_q    <= arb_onehot_d;
                  gnt_id_q <= arb_id_d;
                  hold_q   <= '0;
               end
            end
            S_GRANT: begin
               if (do_write) begin
                  q_q       <= din[gnt_id_q*WIDTH +: WIDTH];
                  q_valid_q <= 1'b1;
                  hold_q    <= hold_q + 4'd1;
               end else begin
                  // Release edge: hand over directly when anyone (including a hold-limited grantee) still asks.
                  last_q <= gnt_id_q;
                  hold_q <= '0;
                  if (req_any) begin
                     gnt_q    <= arb_onehot_d;
                     gnt_id_q <= arb_id_d;
                  end else begin
                     state_q <= S_IDLE;
                     gnt_q   <= '0;
                  end
               end
            end
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign q       = q_q;
   assign q_valid = q_valid_q;
   assign busy    = (state_q == S_GRANT);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_shared_reg_arbiter;
   localparam int NREQ     = 4;
   localparam int WIDTH    = 8;
   localparam int MAX_HOLD = 4;
   localparam int IDW      = $clog2(NREQ);

   logic                    clk;
   logic                    rst;
   logic [NREQ-1:0]         req;
   logic [NREQ*WIDTH-1:0]   din;
   logic [NREQ-1:0]         gnt;
   logic [IDW-1:0]          gnt_id;
   logic [WIDTH-1:0]        q;
   logic                    q_valid;
   logic                    busy;

   int total;
   int bad;

   // Behavioural model state: owner -1 means nobody holds the register.
   int               m_owner;
   int               m_writes;
   int               m_last;
   int               m_gid;
   logic [WIDTH-1:0] m_q;
   logic             m_qv;

   shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
      .gnt_id(gnt_id), .q(q), .q_valid(q_valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [NREQ-1:0] rq, input int last);
      int w;
      w = -1;
`ifdef SHARED_REG_PRIO0_EN
      if (rq[0]) return 0;
`endif
      for (int k = 1; k <= NREQ; k++) begin
         if (w < 0 && rq[(last + k) % NREQ]) w = (last + k) % NREQ;
      end
      return w;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_owner = -1; m_writes = 0; m_last = NREQ - 1; m_gid = 0; m_q = '0; m_qv = 1'b0;
         return;
      end
      m_qv = 1'b0;
      if (m_owner < 0) begin
         if (req != '0) begin
            m_owner = pick(req, m_last); m_gid = m_owner; m_writes = 0;
         end
      end else if (req[m_owner] && m_writes < MAX_HOLD) begin
         m_q = din[m_owner*WIDTH +: WIDTH]; m_writes++; m_qv = 1'b1;
      end else begin
         m_last = m_owner;
         m_writes = 0;
         if (req != '0) begin
            m_owner = pick(req, m_last); m_gid = m_owner;
         end else begin
            m_owner = -1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_din(input int idx, input logic [WIDTH-1:0] v);
      din[idx*WIDTH +: WIDTH] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; din = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111;
      tick(); tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=%h", q, 8'h00); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b exp=0", q_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
      rst = 1'b0; req = 4'b0001;
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt got=%b exp=%b", gnt, 4'b0001); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
      req = '0;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_idle_gnt got=%b exp=%b", gnt, 4'b0000); end
      $display("test_reset done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_single_write();
      do_reset();
      req = 4'b0100; set_din(2, 8'hA5);
      tick();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
      total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL single_gnt_id got=%0d exp=2", gnt_id); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL single_grant_qv got=%b exp=0", q_valid); end
      for (int n = 0; n < 2; n++) begin
         tick();
         total++; if (q !== 8'hA5) begin bad++; $display("FAIL single_q w%0d got=%h exp=a5", n, q); end
         total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL single_qv w%0d got=%b exp=1", n, q_valid); end
      end
      req = '0; set_din(2, 8'h00);
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b exp=0000", gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_rel_busy got=%b exp=0", busy); end
      total++; if (q !== 8'hA5) begin bad++; $display("FAIL single_rel_q got=%h exp=a5", q); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL single_rel_qv got=%b exp=0", q_valid); end
      total++; if (gnt_id !== 2'd2) begin bad++; $display("FAIL single_rel_gnt_id got=%0d exp=2", gnt_id); end
      $display("test_single_write done: total=%0d bad=%0d", total, bad);
   endtask

   // With everyone requesting, each tenure is one grant edge then MAX_HOLD write edges.
   task automatic test_fairness();
      logic [NREQ-1:0] e;
      int g;
      int pos;
      do_reset();
      req = '1;
      for (int i = 0; i < NREQ; i++) set_din(i, 8'(16 + i));
      for (int n = 1; n <= 5 * NREQ + 1; n++) begin
         tick();
         g = ((n - 1) / (MAX_HOLD + 1)) % NREQ;
         pos = (n - 1) % (MAX_HOLD + 1);
         e = '0; e[g] = 1'b1;
         total++; if (gnt !== e) begin bad++; $display("FAIL fair_gnt edge=%0d got=%b exp=%b", n, gnt, e); end
         total++; if (q_valid !== (pos != 0)) begin bad++; $display("FAIL fair_qv edge=%0d got=%b exp=%b", n, q_valid, pos != 0); end
         if (pos != 0) begin
            total++; if (q !== 8'(16 + g)) begin bad++; $display("FAIL fair_q edge=%0d got=%h exp=%h", n, q, 8'(16 + g)); end
         end
      end
      $display("test_fairness done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_hold_lone();
      logic [WIDTH-1:0] v;
      int pos;
      do_reset();
      req = 4'b0010;
      for (int n = 1; n <= 11; n++) begin
         v = 8'($urandom);
         set_din(1, v);
         tick();
         pos = (n - 1) % (MAX_HOLD + 1);
         total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lone_gnt edge=%0d got=%b exp=0010", n, gnt); end
         total++; if (gnt_id !== 2'd1) begin bad++; $display("FAIL lone_gnt_id edge=%0d got=%0d exp=1", n, gnt_id); end
         total++; if (q_valid !== (pos != 0)) begin bad++; $display("FAIL lone_qv edge=%0d got=%b exp=%b", n, q_valid, pos != 0); end
         if (pos != 0) begin
            total++; if (q !== v) begin bad++; $display("FAIL lone_q edge=%0d got=%h exp=%h", n, q, v); end
         end
      end
      $display("test_hold_lone done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_early_release();
      do_reset();
      req = 4'b1000; set_din(3, 8'h3C);
      tick();
      total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL early_gnt3 got=%b exp=1000", gnt); end
      tick();
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL early_q3 got=%h exp=3c", q); end
      req = 4'b0001; set_din(0, 8'h77);
      tick();
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL early_handover got=%b exp=0001", gnt); end
      total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL early_gnt_id got=%0d exp=0", gnt_id); end
      total++; if (q !== 8'h3C) begin bad++; $display("FAIL early_q_hold got=%h exp=3c", q); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL early_qv got=%b exp=0", q_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL early_busy got=%b exp=1", busy); end
      tick();
      total++; if (q !== 8'h77) begin bad++; $display("FAIL early_q0 got=%h exp=77", q); end
      total++; if (q_valid !== 1'b1) begin bad++; $display("FAIL early_qv0 got=%b exp=1", q_valid); end
      $display("test_early_release done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_mid_reset_prio();
      logic [NREQ-1:0] e;
      int w;
      do_reset();
      req = 4'b0100; set_din(2, 8'h5A);
      tick(); tick();
      total++; if (q !== 8'h5A) begin bad++; $display("FAIL mid_q_before got=%h exp=5a", q); end
      rst = 1'b1;
      tick();
      total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
      total++; if (q !== 8'h00) begin bad++; $display("FAIL mid_rst_q got=%h exp=00", q); end
      total++; if (q_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_qv got=%b exp=0", q_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      rst = 1'b0; req = 4'b0001;
      tick();
      req = '0;
      tick();
      // last pointer is now 0; requesters 0,1,3 compete.
      req = 4'b1011;
`ifdef SHARED_REG_PRIO0_EN
      w = 0;
`else
      w = 1;
`endif
      tick();
      e = '0; e[w] = 1'b1;
      total++; if (gnt !== e) begin bad++; $display("FAIL prio_gnt got=%b exp=%b", gnt, e); end
      total++; if (gnt_id !== 2'(w)) begin bad++; $display("FAIL prio_gnt_id got=%0d exp=%0d", gnt_id, w); end
      $display("test_mid_reset_prio done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_random();
      logic [NREQ-1:0] e;
      do_reset();
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         req = req ^ (NREQ'($urandom) & NREQ'($urandom) & NREQ'($urandom));
         for (int i = 0; i < NREQ; i++) set_din(i, 8'($urandom));
         tick();
         e = '0;
         if (m_owner >= 0) e[m_owner] = 1'b1;
         total++; if (gnt !== e) begin bad++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", n, gnt, e); end
         total++; if (gnt_id !== 2'(m_gid)) begin bad++; $display("FAIL rand_gnt_id cyc=%0d got=%0d exp=%0d", n, gnt_id, m_gid); end
         total++; if (q !== m_q) begin bad++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", n, q, m_q); end
         total++; if (q_valid !== m_qv) begin bad++; $display("FAIL rand_qv cyc=%0d got=%b exp=%b", n, q_valid, m_qv); end
         total++; if (busy !== (m_owner >= 0)) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", n, busy, m_owner >= 0); end
      end
      rst = 1'b0;
      $display("test_random done: total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; req = '0; din = '0;
      m_owner = -1; m_writes = 0; m_last = NREQ - 1; m_gid = 0; m_q = '0; m_qv = 1'b0;
      test_reset();
      test_single_write();
      test_fairness();
      test_hold_lone();
      test_early_release();
      test_mid_reset_prio();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
